// File: rtl/tail_light_sequencer.sv
// Automotive tail-light sequencer: left/right turn sweeps, hazard flashing and
// brake override for N_LIGHTS lamps per side, paced by a STEP_CYCLES step timer.
module tail_light_sequencer #(
    parameter int N_LIGHTS    = 3,
    parameter int STEP_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                left,
    input  logic                right,
    input  logic                haz,
    input  logic                brake,
    output logic [N_LIGHTS-1:0] l_lights,
    output logic [N_LIGHTS-1:0] r_lights
);

    localparam int STEP_MAX = (STEP_CYCLES > 2) ? STEP_CYCLES : 2;
    localparam int TW       = $clog2(STEP_MAX);
    localparam int IW       = $clog2(N_LIGHTS + 1);

    localparam logic [TW-1:0]       TICK_VAL = TW'(STEP_CYCLES - 1);
    localparam logic [TW-1:0]       TMR_ZERO = {TW{1'b0}};
    localparam logic [TW-1:0]       TMR_ONE  = TW'(1);
    localparam logic [IW-1:0]       IDX_ONE  = IW'(1);
    localparam logic [IW-1:0]       IDX_LAST = IW'(N_LIGHTS);
    localparam logic [N_LIGHTS-1:0] ALL_ON   = {N_LIGHTS{1'b1}};
    localparam logic [N_LIGHTS-1:0] ALL_OFF  = {N_LIGHTS{1'b0}};

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LSEQ    = 3'd1,
        RSEQ    = 3'd2,
        HAZ_ON  = 3'd3,
        HAZ_OFF = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          ready_q, ready_d;
    logic          tick_s;
    logic          haz_req_s;
    logic [N_LIGHTS-1:0] fill_s;

    assign tick_s    = (timer_q == TICK_VAL);
    assign haz_req_s = haz | (left & right);

    // State, step index, ready flag and step timer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= TMR_ZERO;
            idx_q   <= IDX_ONE;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            ready_q <= ready_d;
        end
    end

    // Next-state logic; every transition except the ready-IDLE launch lands on a tick,
    // where the free-running timer wraps to zero by itself
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ready_d = ready_q;
        timer_d = tick_s ? TMR_ZERO : (timer_q + TMR_ONE);
        case (state_q)
            IDLE: begin
                // An unready IDLE waits out one step, then accepts requests at its tick
                if (ready_q || tick_s) begin
                    timer_d = TMR_ZERO;
                    ready_d = 1'b1;
                    idx_d   = IDX_ONE;
                    if (haz_req_s) begin
                        state_d = HAZ_ON;
                    end else if (left) begin
                        state_d = LSEQ;
                    end else if (right) begin
                        state_d = RSEQ;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            LSEQ, RSEQ: begin
                if (tick_s) begin
                    if (haz_req_s) begin
                        state_d = HAZ_ON;
                        idx_d   = IDX_ONE;
                    end else if (idx_q < IDX_LAST) begin
                        idx_d = idx_q + IDX_ONE;
                    end else begin
                        state_d = IDLE;
                        ready_d = 1'b0;
                        idx_d   = IDX_ONE;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            HAZ_ON: begin
                if (tick_s) begin
                    state_d = HAZ_OFF;
                end else begin
                    state_d = HAZ_ON;
                end
            end
            HAZ_OFF: begin
                if (tick_s) begin
                    if (haz_req_s) begin
                        state_d = HAZ_ON;
                    end else begin
                        state_d = IDLE;
                        ready_d = 1'b1;
                    end
                end else begin
                    state_d = HAZ_OFF;
                end
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
                idx_d   = IDX_ONE;
                timer_d = TMR_ZERO;
            end
        endcase
    end

    // Thermometer fill for the active sequence: lamps below idx are lit
    always_comb begin
        fill_s = ALL_OFF;
        for (int i = 0; i < N_LIGHTS; i++) begin
            fill_s[i] = (i < int'(idx_q));
        end
    end

    // Lamp drive; brake reaches the lamps combinationally, never during hazard flashing
    always_comb begin
        l_lights = ALL_OFF;
        r_lights = ALL_OFF;
        case (state_q)
            IDLE: begin
                l_lights = brake ? ALL_ON : ALL_OFF;
                r_lights = brake ? ALL_ON : ALL_OFF;
            end
            LSEQ: begin
                l_lights = fill_s;
                r_lights = brake ? ALL_ON : ALL_OFF;
            end
            RSEQ: begin
                l_lights = brake ? ALL_ON : ALL_OFF;
                r_lights = fill_s;
            end
            HAZ_ON: begin
                l_lights = ALL_ON;
                r_lights = ALL_ON;
            end
            HAZ_OFF: begin
                l_lights = ALL_OFF;
                r_lights = ALL_OFF;
            end
            default: begin
                l_lights = ALL_OFF;
                r_lights = ALL_OFF;
            end
        endcase
    end

endmodule

// File: tb/tb_tail_light_sequencer.sv
// Bench for tail_light_sequencer: two configurations (3 lamps/4 cycles, 5 lamps/1 cycle)
// share directed and random stimulus and are checked against a phase/step reference model.
module tb_tail_light_sequencer;

    logic       clk = 1'b0;
    logic       rst_s = 1'b1;
    logic       left_s = 1'b0, right_s = 1'b0, haz_s = 1'b0, brake_s = 1'b0;
    logic [2:0] l0, r0;
    logic [4:0] l1, r1;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    int NL [2] = '{3, 5};
    int SC [2] = '{4, 1};

    // Reference model: phase 0 idle, 1 left sweep, 2 right sweep, 3 flash on, 4 flash off
    int m_ph   [2];
    int m_rdy  [2];
    int m_step [2];
    int m_cnt  [2];

    tail_light_sequencer #(.N_LIGHTS(3), .STEP_CYCLES(4)) dut_a (
        .clk(clk), .rst(rst_s), .left(left_s), .right(right_s), .haz(haz_s),
        .brake(brake_s), .l_lights(l0), .r_lights(r0));

    tail_light_sequencer #(.N_LIGHTS(5), .STEP_CYCLES(1)) dut_b (
        .clk(clk), .rst(rst_s), .left(left_s), .right(right_s), .haz(haz_s),
        .brake(brake_s), .l_lights(l1), .r_lights(r1));

    always #5 clk = ~clk;

    function automatic logic [31:0] ones(input int k);
        return (32'd1 << k) - 32'd1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_ph[i] = 0; m_rdy[i] = 1; m_step[i] = 1; m_cnt[i] = 0;
        end
    endtask

    // Advance one clock of the model using the inputs present at that edge
    task automatic model_step(input int i, input bit l, input bit r, input bit h, input bit rs);
        bit hz, done;
        hz   = h | (l & r);
        done = (m_cnt[i] + 1 >= SC[i]);
        if (rs) begin
            m_ph[i] = 0; m_rdy[i] = 1; m_step[i] = 1; m_cnt[i] = 0;
            return;
        end
        case (m_ph[i])
            0: begin
                if (m_rdy[i] == 0 && !done) m_cnt[i]++;
                else begin
                    m_rdy[i] = 1; m_cnt[i] = 0; m_step[i] = 1;
                    if (hz) m_ph[i] = 3;
                    else if (l) m_ph[i] = 1;
                    else if (r) m_ph[i] = 2;
                end
            end
            1, 2: begin
                if (!done) m_cnt[i]++;
                else begin
                    m_cnt[i] = 0;
                    if (hz) m_ph[i] = 3;
                    else if (m_step[i] < NL[i]) m_step[i]++;
                    else begin m_ph[i] = 0; m_rdy[i] = 0; m_step[i] = 1; end
                end
            end
            3: begin
                if (!done) m_cnt[i]++;
                else begin m_cnt[i] = 0; m_ph[i] = 4; end
            end
            default: begin
                if (!done) m_cnt[i]++;
                else begin
                    m_cnt[i] = 0;
                    if (hz) m_ph[i] = 3;
                    else begin m_ph[i] = 0; m_rdy[i] = 1; end
                end
            end
        endcase
    endtask

    task automatic check_all();
        logic [31:0] el, er, ol, orr, all;
        for (int i = 0; i < 2; i++) begin
            all = ones(NL[i]);
            el = 32'd0; er = 32'd0;
            case (m_ph[i])
                0: begin el = brake_s ? all : 32'd0; er = brake_s ? all : 32'd0; end
                1: begin el = ones(m_step[i]); er = brake_s ? all : 32'd0; end
                2: begin el = brake_s ? all : 32'd0; er = ones(m_step[i]); end
                3: begin el = all; er = all; end
                default: begin el = 32'd0; er = 32'd0; end
            endcase
            ol  = (i == 0) ? 32'(l0) : 32'(l1);
            orr = (i == 0) ? 32'(r0) : 32'(r1);
            chk($sformatf("l_lights[cfg%0d]", i), ol, el);
            chk($sformatf("r_lights[cfg%0d]", i), orr, er);
        end
    endtask

    task automatic run(input bit l, input bit r, input bit h, input bit b, input bit rs, input int n);
        repeat (n) begin
            @(negedge clk);
            left_s = l; right_s = r; haz_s = h; brake_s = b; rst_s = rs;
            #1 check_all();
            @(posedge clk);
            cyc++;
            for (int i = 0; i < 2; i++) model_step(i, l, r, h, rs);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        model_reset();
        #1;
        chk("reset_l0", 32'(l0), 32'h0);
        chk("reset_r1", 32'(r1), 32'h0);

        run(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        // left held from reset release
        run(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        #1 chk("left_first_step", 32'(l0), 32'h1);
        run(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4);
        #1 chk("left_second_step", 32'(l0), 32'h3);
        run(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 25);
        run(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10);
        // hazard raised mid-sweep, then dropped, then a new left
        run(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6);
        run(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 18);
        run(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5);
        run(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10);
        run(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12);
        // brake in idle, during a right sweep, during hazard
        run(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3);
        run(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6);
        run(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3);
        run(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12);
        run(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6);
        run(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4);
        run(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12);
        // reset pulse mid right sweep with right still held
        run(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6);
        run(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1);
        #1 chk("rst_mid_seq_r0", 32'(r0), 32'h0);
        run(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        #1 chk("after_rst_r0", 32'(r0), 32'h1);
        run(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 14);
        // left and right together from a ready idle
        run(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 15);
        run(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        #1 chk("both_turns_haz_l0", 32'(l0), 32'h7);
        run(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3);

        // random segments of held inputs
        for (int s = 0; s < 90; s++) begin
            bit l, r, h, b, rs;
            l  = ($urandom_range(0, 2) == 0);
            r  = ($urandom_range(0, 2) == 0);
            h  = ($urandom_range(0, 5) == 0);
            b  = ($urandom_range(0, 3) == 0);
            rs = ($urandom_range(0, 30) == 0);
            run(l, r, h, b, rs, rs ? 1 : $urandom_range(1, 12));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
